// File: rtl/module_bin_to_bcd_pkg.sv
// module_bin_to_bcd_pkg: shared types and defaults for the binary-to-BCD converter.
package module_bin_to_bcd_pkg;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;
    typedef enum logic {IDLE, SHIFT} state_t;
    typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/module_bcd_add3.sv
// module_bcd_add3: double-dabble correction cell, adds 3 to a digit of 5 or more.
module module_bcd_add3
    import module_bin_to_bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/module_bin_to_bcd.sv
// module_bin_to_bcd: sequential shift-add-3 converter, one binary bit per clock.
module module_bin_to_bcd
    import module_bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);
    localparam int CW = $clog2(WIDTH);
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t              state_q, state_d;
    logic [BW+WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [BW-1:0]       corr;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        module_bcd_add3 u_add3 (
            .d(sr_q[WIDTH+4*g +: 4]),
            .q(corr[4*g +: 4])
        );
    end

    // scratch digits and the binary operand live in one register so a single shift moves the MSB across
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                sr_d    = {{BW{1'b0}}, bin_in};
                cnt_d   = '0;
                busy_d  = 1'b1;
                state_d = SHIFT;
            end
        end else begin
            sr_d  = {corr, sr_q[WIDTH-1:0]} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                bcd_d   = sr_d[BW+WIDTH-1:WIDTH];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
endmodule
